instr_seq_ctrl: RTL and testbench
=================================

Name: instr_seq_ctrl

Overview:
- Multi-cycle sequencer for the LUI/ANDI core.
- Fetches instructions over a simple request/valid instruction-memory handshake and holds the instruction register that drives idecode.
- Steps each instruction through DECODE/EXECUTE/WRITEBACK and gates the register-file write.
- Maintains the PC and a retired-instruction counter; halts on an illegal instruction or a memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles FETCH waits for imem_valid before halting (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = fetch/execute continuously, 0 = stop at the next instruction boundary.
- imem_req  out  1  fetch request, held high while in FETCH.
- imem_addr  out  32  fetch address (= pc).
- imem_valid  in  1  rdata valid this cycle; ignored outside FETCH.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction register, drives idecode.instr.
- opcode  in  7  from idecode.opcode.
- rd  in  5  from idecode.rd.
- alu_op  out  1  0 = pass imm_value (LUI), 1 = rs1 AND imm_value (ANDI); valid in EXECUTE and WRITEBACK.
- rf_we  out  1  register-file write strobe, one cycle.
- pc  out  32  program counter.
- instret  out  32  retired-instruction count.
- state  out  3  current FSM state, for debug.
- halted  out  1  sticky halt flag.
- illegal  out  1  sticky; the halt cause was an illegal instruction.
- timeout  out  1  sticky; the halt cause was a fetch timeout.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, instr=0, instret=0, wait counter=0.
  - imem_req=0, rf_we=0, alu_op=0, halted=0, illegal=0, timeout=0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- IDLE:
  - All strobes low.
  - run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc. Wait counter increments each cycle without imem_valid.
  - imem_valid=1 (may arrive in the first FETCH cycle): instr<=imem_rdata, counter clears -> DECODE.
  - Counter reaches TIMEOUT with no valid: timeout<=1, halted<=1 -> HALT. No instr update.
  - imem_valid in the same cycle the counter reaches TIMEOUT: valid wins.
- DECODE (1 cycle):
  - Legal iff opcode==7'b0110111 (LUI), or opcode==7'b0010011 with instr[14:12]==3'b111 (ANDI).
  - Legal -> EXECUTE.
  - Otherwise illegal<=1, halted<=1 -> HALT. pc is not advanced; it points at the offending instruction.
- EXECUTE (1 cycle):
  - alu_op set: LUI -> 0, ANDI -> 1. Registered and held through WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we=1 iff rd!=0. An rd of 0 still retires.
  - pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - instret<=instret+1, wrapping at 2^32.
  - run=1 -> FETCH; run=0 -> IDLE.
- HALT: absorbing; only reset exits. run and imem_valid are ignored.
- run deassertion mid-instruction does not abort; the instruction completes and the FSM returns to IDLE from WRITEBACK.
- Throughput: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXECUTE, WRITEBACK).
- rf_we is Moore: a function of state and the registered rd only. No combinational path from imem_* to any output except through instr.

Decomposition:
- Shared package/include `core_defs`:
  - Opcode constants LUI, OP_IMM, and FUNCT3_ANDI = 3'b111.
  - State encodings.
  - ALU_PASS = 0, ALU_AND = 1.
- The existing idecode is instantiated alongside at core top level, not inside this block.
- Natural sub-module: fetch_timer (wait counter, clear/enable in, expired out).
- Top-level integration module: core_top (instr_seq_ctrl + idecode + regfile + ALU).

Test Plan:
- Reset mid-FETCH -> all outputs at reset values on the same cycle; after release with run=1, imem_req rises and imem_addr=0x0.
- run=1, zero-wait memory returns 0x123452B7 (LUI x5,0x12345) -> DECODE, EXECUTE with alu_op=0, WRITEBACK with rf_we=1; pc 0x0->0x4, instret=1; next FETCH 4 cycles after the first.
- Next word 0x0FF2F313 (ANDI x6,x5,0xFF) delivered after 3 wait cycles -> alu_op=1, rf_we=1 in WRITEBACK; pc=0x8, instret=2.
- Word 0x0FF2F013 (ANDI x0) -> rf_we stays 0; pc advances by 4; instret increments.
- Word 0x00000033 (ADD) -> HALT; illegal=1, halted=1; pc unchanged; run and imem_valid toggling have no further effect.
- imem_valid held low for TIMEOUT=16 cycles -> timeout=1, halted=1; valid arriving on cycle 16 -> normal DECODE.
- pc preloaded via RESET_PC=32'hFFFF_FFFC -> after one retire, pc=0x0.

Source files
------------

// File: rtl/core_defs_pkg.sv
// Shared definitions for the LUI/ANDI core: opcodes, sequencer states, ALU selects.
// No logic; constants and types only.
// Imported by the sequencer and its fetch timer.
package core_defs;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [2:0] FUNCT3_ANDI = 3'b111;

    localparam logic ALU_PASS = 1'b0;
    localparam logic ALU_AND  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

endpackage

// File: rtl/instr_seq_ctrl_fetch_timer.sv
// Fetch wait counter: counts FETCH cycles without imem_valid.
// expired is combinational from the count; it goes high once TIMEOUT-1 cycles have elapsed,
// so the TIMEOUT-th empty cycle is the one that halts. Clear has priority over enable.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import core_defs::*;

    logic [7:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= 8'(TIMEOUT - 1));

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/WRITEBACK, owns instr, pc, instret and halt flags.
// 4 cycles per instruction with zero-wait memory; FETCH stalls until imem_valid or timeout.
// run=0 stops at the next instruction boundary; HALT is left only by reset.
module instr_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    output logic        alu_op,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        timeout
);
    import core_defs::*;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [4:0]  rd_q, rd_d;
    logic        alu_op_q, alu_op_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        tmr_expired;
    logic        is_lui, is_andi;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_fetch_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_q != S_FETCH) || imem_valid),
        .enable  (state_q == S_FETCH),
        .expired (tmr_expired)
    );

    assign is_lui  = (opcode == OPC_LUI);
    assign is_andi = (opcode == OPC_OP_IMM) && (instr_q[14:12] == FUNCT3_ANDI);

    // Next-state and datapath register updates; every register holds unless a state moves it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        rd_d      = rd_q;
        alu_op_d  = alu_op_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // A valid word in the expiry cycle still counts as a fetch.
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                // rd and the ALU select are captured here so WRITEBACK outputs depend on state only.
                if (is_lui || is_andi) begin
                    alu_op_d = is_andi ? ALU_AND : ALU_PASS;
                    rd_d     = rd;
                    state_d  = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            instret_q <= 32'd0;
            rd_q      <= 5'd0;
            alu_op_q  <= ALU_PASS;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            rd_q      <= rd_d;
            alu_op_q  <= alu_op_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign alu_op    = alu_op_q;
    assign rf_we     = (state_q == S_WRITEBACK) && (rd_q != 5'd0);
    assign pc        = pc_q;
    assign instret   = instret_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: vector table of instructions plus hand sequences
// for reset mid-fetch, run stop, illegal halt, fetch timeout and pc wrap.
// Inputs are driven and outputs sampled on the falling edge.
module tb_instr_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run, run2;
    logic        imem_valid, imem_valid2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instr, instr2;
    logic [6:0]  opcode, opcode2;
    logic [4:0]  rd, rd2;
    logic        alu_op, alu_op2;
    logic        rf_we, rf_we2;
    logic [31:0] pc, pc2;
    logic [31:0] instret, instret2;
    logic [2:0]  state, state2;
    logic        halted, halted2;
    logic        illegal, illegal2;
    logic        timeout, timeout2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Stand-in for idecode: plain field extraction from the instruction register.
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign opcode2 = instr2[6:0];
    assign rd2     = instr2[11:7];

    instr_seq_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .rd(rd),
        .alu_op(alu_op), .rf_we(rf_we), .pc(pc), .instret(instret),
        .state(state), .halted(halted), .illegal(illegal), .timeout(timeout)
    );

    instr_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_wrap (
        .clk(clk), .reset(reset), .run(run2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid2), .imem_rdata(imem_rdata2),
        .instr(instr2), .opcode(opcode2), .rd(rd2),
        .alu_op(alu_op2), .rf_we(rf_we2), .pc(pc2), .instret(instret2),
        .state(state2), .halted(halted2), .illegal(illegal2), .timeout(timeout2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] word;
        int          waits;
        logic        exp_alu;
        logic        exp_we;
        logic [31:0] exp_pc;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs[5];

    // Runs one instruction on dut starting from a FETCH-state falling edge, run held at 1.
    task automatic exec_one(input vec_t v);
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, v.exp_pc - 32'd4);
        for (int i = 0; i < v.waits; i++) begin
            imem_valid = 1'b0;
            @(negedge clk);
        end
        chk("still_fetch", 32'(state), 32'd1);
        imem_valid = 1'b1;
        imem_rdata = v.word;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("decode_state", 32'(state), 32'd2);
        chk("instr_reg", instr, v.word);
        chk("decode_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("exec_state", 32'(state), 32'd3);
        chk("exec_alu_op", 32'(alu_op), 32'(v.exp_alu));
        chk("exec_rf_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("wb_state", 32'(state), 32'd4);
        chk("wb_alu_op", 32'(alu_op), 32'(v.exp_alu));
        chk("wb_rf_we", 32'(rf_we), 32'(v.exp_we));
        @(negedge clk);
        chk("next_fetch", 32'(state), 32'd1);
        chk("pc_after", pc, v.exp_pc);
        chk("instret_after", instret, v.exp_instret);
        chk("rf_we_after", 32'(rf_we), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h1234_52B7, 0,  1'b0, 1'b1, 32'h04, 32'd1};  // LUI x5,0x12345
        vecs[1] = '{32'h0FF2_F313, 3,  1'b1, 1'b1, 32'h08, 32'd2};  // ANDI x6,x5,0xFF
        vecs[2] = '{32'h0FF2_F013, 0,  1'b1, 1'b0, 32'h0C, 32'd3};  // ANDI x0 retires, no write
        vecs[3] = '{32'h1234_5037, 1,  1'b0, 1'b0, 32'h10, 32'd4};  // LUI x0
        vecs[4] = '{32'h000F_F0B7, 15, 1'b0, 1'b1, 32'h14, 32'd5};  // valid on 16th wait cycle

        reset = 1'b1; run = 1'b0; run2 = 1'b0;
        imem_valid = 1'b0; imem_rdata = 32'd0;
        imem_valid2 = 1'b0; imem_rdata2 = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Enter FETCH, then reset asynchronously between clock edges.
        run = 1'b1;
        @(negedge clk);
        chk("pre_reset_fetch", 32'(state), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_flags", {29'd0, halted, illegal, timeout}, 32'd0);
        chk("rst_strobes", {30'd0, rf_we, alu_op}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        foreach (vecs[i]) exec_one(vecs[i]);

        // run dropped before the fetch completes: instruction finishes, then IDLE.
        run = 1'b0;
        imem_valid = 1'b1; imem_rdata = 32'h0000_2137;  // LUI x2
        @(negedge clk);
        imem_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_idle", 32'(state), 32'd0);
        chk("stop_pc", pc, 32'h18);
        chk("stop_instret", instret, 32'd6);
        repeat (2) @(negedge clk);
        chk("idle_hold", 32'(state), 32'd0);
        chk("idle_req", 32'(imem_req), 32'd0);
        run = 1'b1;
        @(negedge clk);
        chk("restart_fetch", 32'(state), 32'd1);

        // Illegal instruction (ADD) halts without advancing pc.
        imem_valid = 1'b1; imem_rdata = 32'h0000_0033;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("ill_state", 32'(state), 32'd5);
        chk("ill_flags", {29'd0, halted, illegal, timeout}, 32'b110);
        chk("ill_pc", pc, 32'h18);
        for (int i = 0; i < 6; i++) begin
            run = i[0]; imem_valid = ~i[0]; imem_rdata = 32'h0000_00B7;
            @(negedge clk);
        end
        imem_valid = 1'b0; run = 1'b1;
        chk("halt_absorb", 32'(state), 32'd5);
        chk("halt_pc", pc, 32'h18);
        chk("halt_instret", instret, 32'd6);
        chk("halt_flags", {29'd0, halted, illegal, timeout}, 32'b110);

        // Fetch timeout: 16 empty FETCH cycles halt.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("to_fetch", 32'(state), 32'd1);
        repeat (15) @(negedge clk);
        chk("to_not_yet", 32'(state), 32'd1);
        @(negedge clk);
        chk("to_state", 32'(state), 32'd5);
        chk("to_flags", {29'd0, halted, illegal, timeout}, 32'b101);
        chk("to_instr", instr, 32'd0);

        // pc wrap on the second instance.
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
        run2 = 1'b1;
        @(negedge clk);
        chk("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        imem_valid2 = 1'b1; imem_rdata2 = 32'h000F_F0B7;
        @(negedge clk);
        imem_valid2 = 1'b0; run2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrap_rf_we", 32'(rf_we2), 32'd1);
        @(negedge clk);
        chk("wrap_pc", pc2, 32'd0);
        chk("wrap_instret", instret2, 32'd1);
        chk("wrap_idle", 32'(state2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
